// File: rtl/pulse_scheduler_pkg.sv
// -----------------------------------------------------------------------------
// pulse_scheduler_pkg
// Shared types and default widths for the pulse scheduler slice.
//   ps_state_e        : scheduler FSM states (IDLE, RUN)
//   PS_*              : default parameter values used by pulse_scheduler
//   ps_counter_width  : phase-counter width for a given period width
// Optional feature macro: PULSE_SCHEDULER_PHASE_EN (adds a first-tick phase
// offset, which needs one extra counter bit so phase+period cannot overflow).
// -----------------------------------------------------------------------------
package pulse_scheduler_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } ps_state_e;

  localparam int unsigned PS_PERIOD_BITS    = 16;
  localparam int unsigned PS_COUNT_BITS     = 8;
  localparam int unsigned PS_DEFAULT_PERIOD = 1;

`ifdef PULSE_SCHEDULER_PHASE_EN
  localparam int unsigned PS_PHASE_EXTRA_BITS = 1;
`else
  localparam int unsigned PS_PHASE_EXTRA_BITS = 0;
`endif

  function automatic int unsigned ps_counter_width(input int unsigned period_bits);
    return period_bits + PS_PHASE_EXTRA_BITS;
  endfunction

endpackage

// File: rtl/pulse_scheduler_period_counter.sv
// -----------------------------------------------------------------------------
// period_counter
// Runtime-loadable modulo counter: counts 0..limit while enabled, then wraps.
//   clk, rst_n : clock, asynchronous active-low reset
//   clear      : force count to 0 (used when a run is launched)
//   enable     : advance the count this cycle
//   limit      : terminal value; wrap happens on the edge where count==limit
//   at_limit   : combinational, a wrap happens on the coming edge
//   wrap       : registered one-cycle pulse following each wrap edge
// -----------------------------------------------------------------------------
module period_counter #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             enable,
  input  logic [WIDTH-1:0] limit,
  output logic             at_limit,
  output logic             wrap
);

  logic [WIDTH-1:0] count_q;

  assign at_limit = enable && (count_q == limit);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      wrap    <= 1'b0;
    end else begin
      if (clear) begin
        count_q <= '0;
      end else if (enable) begin
        count_q <= at_limit ? '0 : count_q + 1'b1;
      end
      wrap <= at_limit && !clear;
    end
  end

endmodule

// File: rtl/pulse_scheduler.sv
// -----------------------------------------------------------------------------
// pulse_scheduler
// Runtime-programmable tick source: issues one-cycle tick enables every
// period+1 cycles, either continuously (count 0) or as a burst of count ticks.
//   clk, rst_n        : clock, asynchronous active-low reset
//   cfg_valid/ready   : config handshake, accepted only while idle
//   cfg_period        : period P, ticks are spaced P+1 cycles
//   cfg_count         : burst length N, 0 means run until stopped
//   cfg_phase         : (PULSE_SCHEDULER_PHASE_EN only) extra delay before the
//                       first tick of a run
//   start, stop       : level-sampled run control, stop has priority
//   busy              : high while running
//   tick, done        : registered one-cycle pulses; done marks the last
//                       tick of a burst
// Optional feature macro: PULSE_SCHEDULER_PHASE_EN.
// -----------------------------------------------------------------------------
module pulse_scheduler
  import pulse_scheduler_pkg::*;
#(
  parameter int unsigned PERIOD_BITS    = PS_PERIOD_BITS,
  parameter int unsigned COUNT_BITS     = PS_COUNT_BITS,
  parameter int unsigned DEFAULT_PERIOD = PS_DEFAULT_PERIOD
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cfg_valid,
  output logic                   cfg_ready,
  input  logic [PERIOD_BITS-1:0] cfg_period,
  input  logic [COUNT_BITS-1:0]  cfg_count,
`ifdef PULSE_SCHEDULER_PHASE_EN
  input  logic [PERIOD_BITS-1:0] cfg_phase,
`endif
  input  logic                   start,
  input  logic                   stop,
  output logic                   busy,
  output logic                   tick,
  output logic                   done
);

  localparam int unsigned CW = ps_counter_width(PERIOD_BITS);

  ps_state_e              state_q;
  ps_state_e              state_d;
  logic [PERIOD_BITS-1:0] period_reg;
  logic [COUNT_BITS-1:0]  count_reg;
  logic [COUNT_BITS-1:0]  ticks_issued;
  logic [CW-1:0]          limit;
  logic                   cfg_fire;
  logic                   launch;
  logic                   run_en;
  logic                   at_limit;
  logic                   last_tick;

  assign cfg_ready = (state_q == IDLE);
  assign busy      = (state_q == RUN);
  assign cfg_fire  = cfg_valid && cfg_ready;
  assign launch    = (state_q == IDLE) && start && !stop;
  // Gating the counter with !stop is what suppresses a tick on the stop edge.
  assign run_en    = (state_q == RUN) && !stop;
  assign last_tick = at_limit && (count_reg != '0) &&
                     (COUNT_BITS'(ticks_issued + 1'b1) == count_reg);

`ifdef PULSE_SCHEDULER_PHASE_EN
  logic [PERIOD_BITS-1:0] phase_reg;
  logic                   first_lap;

  // The first lap of a run is stretched by the phase offset; the extra
  // counter bit keeps phase+period from wrapping.
  assign limit = first_lap ? ({1'b0, phase_reg} + {1'b0, period_reg})
                           : {1'b0, period_reg};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_reg <= '0;
      first_lap <= 1'b0;
    end else begin
      if (cfg_fire) begin
        phase_reg <= cfg_phase;
      end
      if (launch) begin
        first_lap <= 1'b1;
      end else if (at_limit) begin
        first_lap <= 1'b0;
      end
    end
  end
`else
  assign limit = period_reg;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (launch) state_d = RUN;
      RUN: begin
        if (stop) begin
          state_d = IDLE;
        end else if (last_tick) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Config registers are loaded on the same edge as a launch, so a
  // simultaneous handshake and start runs with the new values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      period_reg   <= PERIOD_BITS'(DEFAULT_PERIOD);
      count_reg    <= '0;
      ticks_issued <= '0;
      done         <= 1'b0;
    end else begin
      if (cfg_fire) begin
        period_reg <= cfg_period;
        count_reg  <= cfg_count;
      end
      if (launch) begin
        ticks_issued <= '0;
      end else if (at_limit) begin
        ticks_issued <= ticks_issued + 1'b1;
      end
      done <= last_tick;
    end
  end

  period_counter #(
    .WIDTH (CW)
  ) u_period_counter (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (launch),
    .enable   (run_en),
    .limit    (limit),
    .at_limit (at_limit),
    .wrap     (tick)
  );

endmodule

// File: tb/tb_pulse_scheduler.sv
// Self-checking bench for pulse_scheduler. The reference model describes a run
// as "edges since start" and predicts ticks arithmetically from the period,
// phase and burst length.
module tb_pulse_scheduler;

  localparam int PB = 16;
  localparam int CB = 8;
  localparam int DP = 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cfg_valid;
  logic          cfg_ready;
  logic [PB-1:0] cfg_period;
  logic [CB-1:0] cfg_count;
`ifdef PULSE_SCHEDULER_PHASE_EN
  logic [PB-1:0] cfg_phase;
`endif
  logic          start;
  logic          stop;
  logic          busy;
  logic          tick;
  logic          done;

  int pass_cnt  = 0;
  int total_cnt = 0;
  int cycle_no  = 0;

  // Reference model state
  bit m_run;
  int m_p, m_n, m_phase, m_edges, m_ticks;
  bit m_tick, m_done;

  always #5 clk = ~clk;

  pulse_scheduler #(
    .PERIOD_BITS    (PB),
    .COUNT_BITS     (CB),
    .DEFAULT_PERIOD (DP)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_period (cfg_period),
    .cfg_count  (cfg_count),
`ifdef PULSE_SCHEDULER_PHASE_EN
    .cfg_phase  (cfg_phase),
`endif
    .start      (start),
    .stop       (stop),
    .busy       (busy),
    .tick       (tick),
    .done       (done)
  );

  task automatic modelReset();
    m_run   = 1'b0;
    m_p     = DP;
    m_n     = 0;
    m_phase = 0;
    m_edges = 0;
    m_ticks = 0;
    m_tick  = 1'b0;
    m_done  = 1'b0;
  endtask

  // Outcome of one rising edge given the inputs currently applied.
  task automatic modelEdge();
    int first;
    m_tick = 1'b0;
    m_done = 1'b0;
    if (!m_run) begin
      if (cfg_valid) begin
        m_p = int'(cfg_period);
        m_n = int'(cfg_count);
`ifdef PULSE_SCHEDULER_PHASE_EN
        m_phase = int'(cfg_phase);
`endif
      end
      if (start && !stop) begin
        m_run   = 1'b1;
        m_edges = 0;
        m_ticks = 0;
      end
    end else if (stop) begin
      m_run = 1'b0;
    end else begin
      m_edges++;
      first = m_phase + m_p + 1;
      if (m_edges >= first && ((m_edges - first) % (m_p + 1)) == 0) begin
        m_tick = 1'b1;
        m_ticks++;
        if (m_n != 0 && m_ticks == m_n) begin
          m_done = 1'b1;
          m_run  = 1'b0;
        end
      end
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("[TB] FAIL %s cycle %0d: observed %b expected %b", tag, cycle_no, obs, exp);
  endtask

  task automatic checkOutput();
    check1("tick", tick, m_tick);
    check1("done", done, m_done);
    check1("busy", busy, m_run);
    check1("cfg_ready", cfg_ready, !m_run);
  endtask

  task automatic applyStimulus(input bit cv, input int cp, input int cc,
                               input bit st, input bit sp);
    cfg_valid  = cv;
    cfg_period = PB'(cp);
    cfg_count  = CB'(cc);
    start      = st;
    stop       = sp;
  endtask

  task automatic stepCycle();
    @(posedge clk);
    modelEdge();
    #1;
    cycle_no++;
    checkOutput();
  endtask

  task automatic idleCycles(input int n);
    applyStimulus(1'b0, 0, 0, 1'b0, 1'b0);
    for (int i = 0; i < n; i++) stepCycle();
  endtask

  task automatic stopRun();
    applyStimulus(1'b0, 0, 0, 1'b0, 1'b1);
    stepCycle();
  endtask

  initial begin
    rst_n = 1'b0;
`ifdef PULSE_SCHEDULER_PHASE_EN
    cfg_phase = '0;
`endif
    applyStimulus(1'b0, 0, 0, 1'b0, 1'b0);
    modelReset();
    #12;
    checkOutput();
    @(negedge clk);
    rst_n = 1'b1;

    // Continuous P=3
    applyStimulus(1'b1, 3, 0, 1'b0, 1'b0);
    stepCycle();
    applyStimulus(1'b0, 3, 0, 1'b1, 1'b0);
    stepCycle();
    idleCycles(14);
    stopRun();
    idleCycles(2);

    // Burst P=2 N=3, config and start on the same edge
    applyStimulus(1'b1, 2, 3, 1'b1, 1'b0);
    stepCycle();
    idleCycles(12);

    // Burst P=0 N=5
    applyStimulus(1'b1, 0, 5, 1'b1, 1'b0);
    stepCycle();
    idleCycles(8);

    // Continuous P=4, stop lands on the edge that would register the first tick
    applyStimulus(1'b1, 4, 0, 1'b1, 1'b0);
    stepCycle();
    idleCycles(4);
    stopRun();
    idleCycles(3);

    // Start and stop together while idle stays idle
    applyStimulus(1'b0, 0, 0, 1'b1, 1'b1);
    stepCycle();

    // Config offered during a run is ignored
    applyStimulus(1'b1, 1, 0, 1'b1, 1'b0);
    stepCycle();
    applyStimulus(1'b1, 9, 2, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) stepCycle();
    stopRun();
    applyStimulus(1'b1, 9, 2, 1'b1, 1'b0);
    stepCycle();
    idleCycles(22);

    // Reset mid-burst, then run with the default period
    applyStimulus(1'b1, 5, 4, 1'b1, 1'b0);
    stepCycle();
    idleCycles(7);
    #2;
    rst_n = 1'b0;
    #1;
    modelReset();
    checkOutput();
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(1'b0, 0, 0, 1'b1, 1'b0);
    stepCycle();
    idleCycles(6);
    stopRun();

`ifdef PULSE_SCHEDULER_PHASE_EN
    // Phase offset 2 with P=3: first tick six edges after start
    cfg_phase = PB'(2);
    applyStimulus(1'b1, 3, 2, 1'b1, 1'b0);
    stepCycle();
    idleCycles(12);
`endif

    // Randomised traffic
    for (int i = 0; i < 400; i++) begin
      applyStimulus(($urandom_range(0, 9) < 3), int'($urandom_range(0, 5)),
                    int'($urandom_range(0, 4)), ($urandom_range(0, 9) < 2),
                    ($urandom_range(0, 19) < 1));
`ifdef PULSE_SCHEDULER_PHASE_EN
      cfg_phase = PB'($urandom_range(0, 3));
`endif
      stepCycle();
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
